huffman_encoder: RTL

Streaming Huffman encoder for the 4-bit-symbol codec. It maps each input symbol to its variable-length prefix code (1, 4, 5 or 6 bits). It packs the codes MSB-first into 6-bit words for the word-oriented Huffman decoder downstream. A flush command closes a stream with a zero-padded final word, tagged with its count of valid bits.

---
 rtl/huffman_pkg.sv | 61 ++++++
 rtl/huffman_enc_lut.sv | 14 +
 rtl/huffman_encoder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// Shared definitions for the 4-bit-symbol Huffman codec: symbol/word widths,
// the code descriptor type, the encoder FSM states and the code table.
// The decoder side reuses code_lookup so both ends share one table.
package huffman_pkg;

    localparam int SYM_W        = 4;
    localparam int WORD_W       = 6;
    localparam int MAX_CODE_LEN = 6;

    // Left-aligned code: the first code bit sits in bits[MAX_CODE_LEN-1]
    typedef struct packed {
        logic [MAX_CODE_LEN-1:0] bits;
        logic [2:0]              len;
        logic                    valid;
    } code_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam code_t CODE_S0   = '{bits: 6'b100000, len: 3'd1, valid: 1'b1};
    localparam code_t CODE_S1   = '{bits: 6'b010000, len: 3'd4, valid: 1'b1};
    localparam code_t CODE_S2   = '{bits: 6'b010100, len: 3'd4, valid: 1'b1};
    localparam code_t CODE_S3   = '{bits: 6'b011000, len: 3'd6, valid: 1'b1};
    localparam code_t CODE_S4   = '{bits: 6'b011001, len: 3'd6, valid: 1'b1};
    localparam code_t CODE_S5   = '{bits: 6'b001000, len: 3'd4, valid: 1'b1};
    localparam code_t CODE_S6   = '{bits: 6'b001100, len: 3'd4, valid: 1'b1};
    localparam code_t CODE_S7   = '{bits: 6'b011010, len: 3'd5, valid: 1'b1};
    localparam code_t CODE_S8   = '{bits: 6'b000110, len: 3'd6, valid: 1'b1};
    localparam code_t CODE_S9   = '{bits: 6'b011100, len: 3'd4, valid: 1'b1};
    localparam code_t CODE_S10  = '{bits: 6'b000000, len: 3'd4, valid: 1'b1};
    localparam code_t CODE_S12  = '{bits: 6'b000111, len: 3'd6, valid: 1'b1};
    localparam code_t CODE_S14  = '{bits: 6'b000100, len: 3'd6, valid: 1'b1};
    localparam code_t CODE_S15  = '{bits: 6'b000101, len: 3'd6, valid: 1'b1};
    localparam code_t CODE_NONE = '{bits: 6'b000000, len: 3'd0, valid: 1'b0};

    // Symbols 11 and 13 have no code and map to CODE_NONE
    function automatic code_t code_lookup(input logic [SYM_W-1:0] s);
        code_t c;
        case (s)
            4'd0:    c = CODE_S0;
            4'd1:    c = CODE_S1;
            4'd2:    c = CODE_S2;
            4'd3:    c = CODE_S3;
            4'd4:    c = CODE_S4;
            4'd5:    c = CODE_S5;
            4'd6:    c = CODE_S6;
            4'd7:    c = CODE_S7;
            4'd8:    c = CODE_S8;
            4'd9:    c = CODE_S9;
            4'd10:   c = CODE_S10;
            4'd12:   c = CODE_S12;
            4'd14:   c = CODE_S14;
            4'd15:   c = CODE_S15;
            default: c = CODE_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/huffman_enc_lut.sv
// Combinational symbol-to-code lookup for the Huffman encoder.
module huffman_enc_lut
    import huffman_pkg::*;
(
    input  logic [SYM_W-1:0] sym,
    output code_t            code
);

    // Pure table lookup, left-aligned code with its length and validity
    always_comb begin
        code = code_lookup(sym);
    end

endmodule

// File: rtl/huffman_encoder.sv
// Streaming Huffman encoder: packs variable-length codes MSB-first into
// WORD_W-bit words; flush closes the stream with a zero-padded last word.
// Optional feature macro: HUFFMAN_ENC_STATS_EN adds sym_count/err_count.
module huffman_encoder #(
    parameter int WORD_W = 6,
    parameter int ACC_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sym_valid,
    input  logic [3:0]        sym,
    output logic              sym_ready,
    input  logic              flush,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    input  logic              word_ready,
    output logic              word_last,
    output logic [2:0]        word_nbits,
    output logic              sym_err
`ifdef HUFFMAN_ENC_STATS_EN
    ,
    output logic [15:0]       sym_count,
    output logic [15:0]       err_count
`endif
);

    import huffman_pkg::*;

    localparam int                CNT_W = $clog2(ACC_W);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(WORD_W);

    state_t           state;
    logic             flush_pend;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    code_t            code;

    logic             accept;
    logic             slot_free;
    logic             flush_req;
    logic             have_word;
    logic             extract;
    logic             partial;
    logic [ACC_W-1:0] code_ext;

    huffman_enc_lut u_lut (
        .sym  (sym),
        .code (code)
    );

    assign sym_ready = (state == RUN) && (cnt < FULL);
    assign accept    = sym_valid && sym_ready;
    assign slot_free = !word_valid || word_ready;
    assign flush_req = flush || flush_pend;
    assign have_word = (cnt >= FULL);
    // In RUN a pending flush hands the drain over to FLUSH so the final
    // full word can be tagged as last.
    assign extract   = have_word && slot_free && ((state == FLUSH) || !flush_req);
    assign partial   = (state == FLUSH) && !have_word && (cnt != '0) && slot_free;
    // Bits below the fill point are always zero, so OR-ing places the code
    assign code_ext  = {code.bits, {(ACC_W-MAX_CODE_LEN){1'b0}}} >> cnt;

    // Control FSM: RUN accepts symbols, FLUSH drains everything buffered
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            flush_pend <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (flush_pend) begin
                        state      <= FLUSH;
                        flush_pend <= 1'b0;
                    end else if (flush && accept) begin
                        flush_pend <= 1'b1;
                    end else if (flush) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if ((cnt == '0) || partial || (extract && (cnt == FULL))) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Accumulator and fill count: accept and extract never coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept && code.valid) begin
            acc <= acc | code_ext;
            cnt <= cnt + CNT_W'(code.len);
        end else if (extract) begin
            acc <= acc << WORD_W;
            cnt <= cnt - FULL;
        end else if (partial) begin
            acc <= '0;
            cnt <= '0;
        end
    end

    // Output word slot, held stable while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            word_valid <= 1'b0;
            word       <= '0;
            word_nbits <= '0;
            word_last  <= 1'b0;
        end else if (extract) begin
            word_valid <= 1'b1;
            word       <= acc[ACC_W-1 -: WORD_W];
            word_nbits <= 3'(WORD_W);
            word_last  <= (state == FLUSH) && (cnt == FULL);
        end else if (partial) begin
            word_valid <= 1'b1;
            word       <= acc[ACC_W-1 -: WORD_W];
            word_nbits <= cnt[2:0];
            word_last  <= 1'b1;
        end else if (word_ready) begin
            word_valid <= 1'b0;
        end
    end

    // One-cycle error pulse for an accepted symbol without a code
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_err <= 1'b0;
        end else begin
            sym_err <= accept && !code.valid;
        end
    end

`ifdef HUFFMAN_ENC_STATS_EN
    // Wrapping counters of accepted valid and dropped invalid symbols
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_count <= '0;
            err_count <= '0;
        end else begin
            if (accept && code.valid) begin
                sym_count <= sym_count + 16'd1;
            end
            if (accept && !code.valid) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule
